// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-master memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DBG = 1'b1;
    localparam int MEM_LATENCY_MAX = 7;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the master not granted last wins
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       id,
    output logic       valid
);
    assign valid = |req;
    assign id    = (&req) ? ~last_gnt : req[1];
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises two masters onto one fixed-latency memory port
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m0_mask,
    input  logic [3:0]  m1_mask,
    output logic        m0_ready,
    output logic        m1_ready,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rdata,
    output logic        gnt_id,
    output logic        busy
);
    localparam logic [2:0] LAT = 3'(MEM_LATENCY);
    arb_state_t state, state_d;
    logic [2:0]  cnt;
    logic        last_gnt, pick_id, pick_valid, lat_we;
    logic [31:0] rdata_q;
    rr_pick2 u_pick (
        .req      ({m1_req, m0_req}),
        .last_gnt (last_gnt),
        .id       (pick_id),
        .valid    (pick_valid)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = pick_valid ? ACCESS : IDLE;
            ACCESS:  state_d = (lat_we || LAT == 3'd0) ? RESP : WAIT;
            WAIT:    state_d = (cnt == 3'd1) ? RESP : WAIT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_id    <= MST_CPU;
            last_gnt  <= MST_DBG;
            cnt       <= '0;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_mask  <= '0;
            rdata_q   <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                gnt_id    <= pick_id;
                lat_we    <= pick_id ? m1_we    : m0_we;
                mem_addr  <= pick_id ? m1_addr  : m0_addr;
                mem_wdata <= pick_id ? m1_wdata : m0_wdata;
                mem_mask  <= pick_id ? m1_mask  : m0_mask;
            end
            if (state == ACCESS && !lat_we) begin
                if (LAT == 3'd0) rdata_q <= mem_rdata;
                else             cnt     <= LAT;
            end
            if (state == WAIT) begin
                cnt <= (cnt != 3'd0) ? cnt - 3'd1 : 3'd0;
                if (cnt == 3'd1) rdata_q <= mem_rdata;
            end
            if (state != RESP && state_d == RESP) last_gnt <= gnt_id;
        end
    end
    assign mem_en   = (state == ACCESS);
    assign mem_we   = mem_en & lat_we;
    assign busy     = (state != IDLE);
    assign m0_ready = (state == RESP) && (gnt_id == MST_CPU);
    assign m1_ready = (state == RESP) && (gnt_id == MST_DBG);
    assign m0_rdata = rdata_q;
    assign m1_rdata = rdata_q;
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave memory arbiter that shares the single-port instruction/data memory between the multicycle CPU (master 0) and a debug/DMA loader (master 1). It serialises requests, applies round-robin priority on contention, and sequences each access through a fixed-latency memory. It returns a one-cycle ready pulse with read data to the granted master. It sits between the CPU memory port and the memory, and the CPU control sequencer holds its current state until `m0_ready`.

## Interface
- One clock; reset is asynchronous and active-low.
- `MEM_LATENCY`, default 0: cycles from the memory access cycle to valid `mem_rdata`; legal range 0..7, where 0 means combinational read.
- `clk`  in  1  clock
- `reset`  in  1  async active-low reset; asserted when 0
- `m0_req`, `m1_req`  in  1  request, held until the matching ready
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  32  byte address
- `m0_wdata`, `m1_wdata`  in  32  write data
- `m0_mask`, `m1_mask`  in  4  byte-lane mask
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse
- `m0_rdata`, `m1_rdata`  out  32  read data, valid while ready is high
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable, only high together with `mem_en`
- `mem_addr`  out  32  memory address
- `mem_wdata`  out  32  memory write data
- `mem_mask`  out  4  memory byte-lane mask
- `mem_rdata`  in  32  memory read data
- `gnt_id`  out  1  master currently owning the bus
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- **States:** IDLE, ACCESS, WAIT, RESP.
- **IDLE:**
  - If any `req` is high at the clock edge, the arbiter picks a winner and latches that winner's we/addr/wdata/mask into internal registers.
  - It sets `gnt_id` to the winner and moves to ACCESS.
- **Arbitration:**
  - A single requester wins.
  - If both request, the winner is the master that is not `last_gnt`.
  - `last_gnt` updates on entering RESP.
- **ACCESS:**
  - Exactly one cycle with `mem_en`=1.
  - `mem_we` = latched we; address, data and mask come from the latched registers.
  - Write: go to RESP.
  - Read with `MEM_LATENCY`=0: capture `mem_rdata` at this edge, then go to RESP.
  - Otherwise: load the counter with `MEM_LATENCY` and go to WAIT.
- **WAIT:**
  - The counter decrements each cycle.
  - When the counter is 1, capture `mem_rdata` at that edge and go to RESP.
  - The counter is 3 bits wide and never wraps.
- **RESP:**
  - The granted master's ready is high for one cycle, with rdata equal to the captured word (writes return the last captured word).
  - Then go to IDLE unconditionally; any `req` seen during RESP is not sampled.
- **Outputs outside ACCESS:** `mem_en` and `mem_we` are 0; `mem_addr`, `mem_wdata` and `mem_mask` hold the latched values.
- **Request dropped mid-transaction:** the transaction still completes and ready still pulses. The request signals are only sampled in IDLE.
- **Request changed after acceptance:** ignored; the latched copy is used.
- **Fairness:** a waiting master is delayed by at most one transaction of the other master.
- **Reset (any state):**
  - state = IDLE, `last_gnt` = 1 (so master 0 wins the first tie), `gnt_id` = 0.
  - Counter, latched registers and captured data = 0.
  - All ready outputs, `mem_en`, `mem_we` and `busy` = 0.
  - An in-flight access is abandoned with no ready pulse.

## Timing
- Request first high in cycle 0 while in IDLE: ACCESS is cycle 1 and ready is high in cycle 2 + L, where L = `MEM_LATENCY` for reads and 0 for writes.
- Back-to-back: a master holding `req` through its ready pulse is re-sampled in the following IDLE cycle. A read costs 3 + `MEM_LATENCY` cycles; a write costs 3 cycles.
- All outputs are registered-state decodes; there is no combinational path from `req` to `mem_en` or `ready`.
- `mem_rdata` is sampled only on the capture edge defined above.

## Structure
- Package `mem_arb_pkg`:
  - State enum typedef `arb_state_t` (IDLE, ACCESS, WAIT, RESP).
  - Master-ID constants `MST_CPU`=0 and `MST_DBG`=1.
  - `MEM_LATENCY_MAX`=7.
- Sub-module `rr_pick2`: combinational two-way round-robin selection from req[1:0] and `last_gnt`, producing the winner id and a valid flag.
- The FSM, counter and latches live in the top module.

## Test plan
- Master 0 read of 0x100 alone, `MEM_LATENCY`=0, memory returns 0xDEADBEEF → `mem_en` in cycle 1; `m0_ready`=1 and `m0_rdata`=0xDEADBEEF in cycle 2; `m1_ready` stays 0.
- Both masters issue writes in the same cycle after reset → master 0 is served first (`mem_addr` = its address, `mem_we`=1), then master 1; with both held high continuously, grants alternate 0,1,0,1.
- `MEM_LATENCY`=3, master 1 read of 0x2000 → exactly 3 WAIT cycles, `m1_ready` in cycle 5, data equals `mem_rdata` from the last WAIT cycle; earlier `mem_rdata` values are ignored.
- Master 0 drops `req` and changes `m0_addr` to 0xFFFF during ACCESS → `mem_addr` remains the original address and `m0_ready` still pulses once.
- `reset`=0 asserted during WAIT → immediately `busy`=0, `mem_en`=0, no ready pulse; after release a simultaneous request is granted to master 0.
- Master 1 holds `req` for 4 back-to-back writes while master 0 is idle → master 1 completes one write every 3 cycles; master 0 then raises `req` and is granted next.
